// File: rtl/board_status_monitor.sv
// ----------------------------------------------------------------------------
// board_status_monitor
//
// Board-level status/indicator block. Drives LEDs and six active-low
// seven-segment digits from a phase array, an FT read-error flag and a
// phase-update strobe.
//
// Ports:
//   sys_clk        system clock
//   rst            synchronous active-high reset
//   phases         unpacked phase array [0:NUM_CHANNELS-1]
//   phase_update   single-cycle strobe: phases changed
//   read_error     level error flag from the FT reader
//   err_clr        clears the sticky error and its count
//   sel            displayed channel index
//   freeze         holds the displayed values
//   led_phase      latched phase of the selected channel
//   led_error      sticky error
//   led_activity   stretched update indicator
//   led_heartbeat  heartbeat
//   hex            active-low segments [0:5], bit order {g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
module board_status_monitor #(
    parameter int NUM_CHANNELS   = 2,
    parameter int PHASE_WIDTH    = 8,
    parameter int SEL_WIDTH      = 8,
    parameter int HB_BITS        = 25,
    parameter int STRETCH_CYCLES = 5000000
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic [PHASE_WIDTH-1:0] phases [0:NUM_CHANNELS-1],
    input  logic                   phase_update,
    input  logic                   read_error,
    input  logic                   err_clr,
    input  logic [SEL_WIDTH-1:0]   sel,
    input  logic                   freeze,
    output logic [PHASE_WIDTH-1:0] led_phase,
    output logic                   led_error,
    output logic                   led_activity,
    output logic                   led_heartbeat,
    output logic [6:0]             hex [0:5]
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam int         ACT_W     = $clog2(STRETCH_CYCLES + 1);
    // Wide enough to compare sel against channel indices without truncation.
    localparam int         CMP_W     = SEL_WIDTH + 32;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Heartbeat
    // ------------------------------------------------------------------
    logic [HB_BITS-1:0] hb_cnt;
    logic [HB_BITS-1:0] hb_next;

    assign hb_next = hb_cnt + 1'b1;

    // The LED follows the MSB of the incremented count so that it rises on
    // the 2^(HB_BITS-1)-th edge after reset while still being a flop output.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            hb_cnt        <= '0;
            led_heartbeat <= 1'b0;
        end else begin
            hb_cnt        <= hb_next;
            led_heartbeat <= hb_next[HB_BITS-1];
        end
    end

    // ------------------------------------------------------------------
    // Display shadow
    // ------------------------------------------------------------------
    logic [SEL_WIDTH-1:0]   sel_q;
    logic [PHASE_WIDTH-1:0] phase_q;
    logic                   valid;
    logic [PHASE_WIDTH-1:0] sel_phase;
    logic                   sel_q_ok;
    logic                   load;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        sel_phase = '0;
        sel_q_ok  = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (CMP_W'(sel) == CMP_W'(i))   sel_phase = phases[i];
            if (CMP_W'(sel_q) == CMP_W'(i)) sel_q_ok  = 1'b1;
        end
    end

    assign load = !freeze && (phase_update || (sel != sel_q));

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sel_q   <= '0;
            phase_q <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            sel_q   <= sel;
            phase_q <= sel_phase;
            valid   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Error tracking
    // ------------------------------------------------------------------
    logic       err_prev;
    logic       err_rise;
    logic [3:0] err_cnt;

    assign err_rise = read_error && !err_prev;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            err_prev  <= 1'b0;
            led_error <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_prev <= read_error;
            // A new edge in the same cycle as a clear is not lost.
            if (err_clr && err_rise) begin
                led_error <= 1'b1;
                err_cnt   <= 4'd1;
            end else if (err_clr) begin
                led_error <= 1'b0;
                err_cnt   <= '0;
            end else if (err_rise) begin
                led_error <= 1'b1;
                if (err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Activity stretcher (counts strobes even while frozen)
    // ------------------------------------------------------------------
    logic [ACT_W-1:0] act_cnt;
    logic [ACT_W-1:0] act_next;

    always_comb begin
        act_next = act_cnt;
        if (phase_update)      act_next = ACT_W'(STRETCH_CYCLES);
        else if (act_cnt != 0) act_next = act_cnt - 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            act_cnt      <= '0;
            led_activity <= 1'b0;
        end else begin
            act_cnt      <= act_next;
            led_activity <= (act_next != 0);
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic [SEL_WIDTH+7:0]    sel_pad;
    logic [PHASE_WIDTH+11:0] ph_pad;

    // Zero padding supplies the missing high bits for narrow parameters.
    assign sel_pad = {8'b0, sel_q};
    assign ph_pad  = {12'b0, phase_q};

    always_ff @(posedge sys_clk) begin
        if (rst || !valid) begin
            led_phase <= '0;
            for (int i = 0; i < 6; i++) hex[i] <= SEG_BLANK;
        end else begin
            hex[5] <= seg7(sel_pad[7:4]);
            hex[4] <= seg7(sel_pad[3:0]);
            hex[3] <= seg7(err_cnt);
            if (!sel_q_ok) begin
                led_phase <= '0;
                hex[2]    <= SEG_DASH;
                hex[1]    <= SEG_DASH;
                hex[0]    <= SEG_DASH;
            end else begin
                led_phase <= phase_q;
                hex[2]    <= (PHASE_WIDTH > 8) ? seg7(ph_pad[11:8]) : SEG_BLANK;
                hex[1]    <= (PHASE_WIDTH > 4) ? seg7(ph_pad[7:4])  : SEG_BLANK;
                hex[0]    <= seg7(ph_pad[3:0]);
            end
        end
    end

endmodule

// File: tb/tb_board_status_monitor.sv
// ----------------------------------------------------------------------------
// tb_board_status_monitor
//
// Directed bench for board_status_monitor with NUM_CHANNELS=4,
// PHASE_WIDTH=8, HB_BITS=4, STRETCH_CYCLES=3. Inputs change 1 ns after a
// rising edge and outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_board_status_monitor;

    localparam int NCH = 4;
    localparam int PW  = 8;
    localparam int SW  = 8;

    localparam logic [6:0] S_0   = 7'b1000000;
    localparam logic [6:0] S_1   = 7'b1111001;
    localparam logic [6:0] S_3   = 7'b0110000;
    localparam logic [6:0] S_5   = 7'b0010010;
    localparam logic [6:0] S_6   = 7'b0000010;
    localparam logic [6:0] S_A   = 7'b0001000;
    localparam logic [6:0] S_F   = 7'b0001110;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] phases [0:NCH-1];
    logic          phase_update = 1'b0;
    logic          read_error = 1'b0;
    logic          err_clr = 1'b0;
    logic [SW-1:0] sel = '0;
    logic          freeze = 1'b0;
    logic [PW-1:0] led_phase;
    logic          led_error;
    logic          led_activity;
    logic          led_heartbeat;
    logic [6:0]    hex [0:5];

    int tests_run = 0;
    int tests_failed = 0;

    board_status_monitor #(
        .NUM_CHANNELS  (NCH),
        .PHASE_WIDTH   (PW),
        .SEL_WIDTH     (SW),
        .HB_BITS       (4),
        .STRETCH_CYCLES(3)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .phases       (phases),
        .phase_update (phase_update),
        .read_error   (read_error),
        .err_clr      (err_clr),
        .sel          (sel),
        .freeze       (freeze),
        .led_phase    (led_phase),
        .led_error    (led_error),
        .led_activity (led_activity),
        .led_heartbeat(led_heartbeat),
        .hex          (hex)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic check_all_blank(input string tag);
        for (int i = 0; i < 6; i++) check($sformatf("%s_hex%0d", tag, i), hex[i], BLANK);
    endtask

    task automatic strobe();
        phase_update = 1'b1;
        tick();
        phase_update = 1'b0;
    endtask

    initial begin
        phases[0] = 8'h3A;
        phases[1] = 8'hF0;
        phases[2] = 8'h81;
        phases[3] = 8'h00;

        // 1. Reset and idle: heartbeat on edge k equals bit 3 of k.
        tick(2);
        rst = 1'b0;
        check("rst_led_phase", led_phase, 0);
        check("rst_heartbeat", led_heartbeat, 0);
        check("rst_activity", led_activity, 0);
        check("rst_error", led_error, 0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("hb_k%0d", k), led_heartbeat, ((k % 16) >= 8) ? 1 : 0);
        end
        check_all_blank("idle");
        check("idle_led_phase", led_phase, 0);

        // 2. Strobe with sel=0: display appears 2 edges later.
        strobe();
        check("act_after_strobe", led_activity, 1);
        tick();
        check("t2_led_phase", led_phase, 8'h3A);
        check("t2_hex0", hex[0], S_A);
        check("t2_hex1", hex[1], S_3);
        check("t2_hex2", hex[2], BLANK);
        check("t2_hex3", hex[3], S_0);
        check("t2_hex4", hex[4], S_0);
        check("t2_hex5", hex[5], S_0);

        // 3. Channel select change, then out-of-range select.
        sel = 8'd1;
        tick(2);
        check("t3_led_phase", led_phase, 8'hF0);
        check("t3_hex1", hex[1], S_F);
        check("t3_hex0", hex[0], S_0);
        sel = 8'd6;
        tick(2);
        check("t3_oor_led_phase", led_phase, 0);
        check("t3_oor_hex0", hex[0], DASH);
        check("t3_oor_hex1", hex[1], DASH);
        check("t3_oor_hex2", hex[2], DASH);
        check("t3_oor_hex4", hex[4], S_6);
        check("t3_oor_hex5", hex[5], S_0);

        // 4. Freeze blocks loads; activity still stretches for 3 cycles.
        sel = 8'd1;
        tick(6);
        check("t4_pre_led_phase", led_phase, 8'hF0);
        check("t4_pre_activity", led_activity, 0);
        freeze = 1'b1;
        phases[1] = 8'h55;
        strobe();
        check("t4_act_c1", led_activity, 1);
        tick();
        check("t4_act_c2", led_activity, 1);
        tick();
        check("t4_act_c3", led_activity, 1);
        tick();
        check("t4_act_off", led_activity, 0);
        check("t4_frozen_led_phase", led_phase, 8'hF0);
        freeze = 1'b0;
        tick(2);
        check("t4_released_led_phase", led_phase, 8'hF0);
        check("t4_released_hex0", hex[0], S_0);
        strobe();
        tick();
        check("t4_new_led_phase", led_phase, 8'h55);
        check("t4_new_hex0", hex[0], S_5);
        check("t4_new_hex1", hex[1], S_5);

        // 5. Error: level held counts once, then 16 pulses saturate at F.
        read_error = 1'b1;
        tick(10);
        check("t5_held_error", led_error, 1);
        check("t5_held_hex3", hex[3], S_1);
        for (int p = 0; p < 16; p++) begin
            read_error = 1'b0;
            tick();
            read_error = 1'b1;
            tick();
        end
        read_error = 1'b0;
        tick(2);
        check("t5_sat_error", led_error, 1);
        check("t5_sat_hex3", hex[3], S_F);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_clr_error", led_error, 0);
        tick();
        check("t5_clr_hex3", hex[3], S_0);
        read_error = 1'b1;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_coinc_error", led_error, 1);
        tick();
        check("t5_coinc_hex3", hex[3], S_1);
        read_error = 1'b0;

        // 6. Retriggered activity: strobes 2 edges apart give 5 cycles high.
        tick(5);
        check("t6_pre_activity", led_activity, 0);
        strobe();
        check("t6_act_1", led_activity, 1);
        tick();
        check("t6_act_2", led_activity, 1);
        strobe();
        check("t6_act_3", led_activity, 1);
        tick();
        check("t6_act_4", led_activity, 1);
        tick();
        check("t6_act_5", led_activity, 1);
        tick();
        check("t6_act_off", led_activity, 0);

        // Reset mid-stretch forces reset values at the next edge.
        tick(3);
        read_error = 1'b1;
        strobe();
        check("t6_prerst_error", led_error, 1);
        check("t6_prerst_activity", led_activity, 1);
        rst = 1'b1;
        tick();
        check("t6_rst_led_phase", led_phase, 0);
        check("t6_rst_error", led_error, 0);
        check("t6_rst_activity", led_activity, 0);
        check("t6_rst_heartbeat", led_heartbeat, 0);
        check_all_blank("t6_rst");
        rst = 1'b0;
        read_error = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
